// File: rtl/pll_lock_rst_ctrl.sv
// pll_lock_rst_ctrl
//   Reset/lock handshake controller for the board PLL. Runs on the free-running
//   reference clock (the PLL clkin1 net), pulses the PLL reset after power-up,
//   waits for a stable synchronised lock, then releases the downstream reset.
//   Lock timeouts re-reset the PLL up to MAX_RETRY times before latching FAIL;
//   loss of lock while running re-resets without consuming a retry.
//
// Ports
//   clk        in   reference clock (same net as PLL clkin1)
//   rst_n      in   asynchronous active-low reset
//   pll_lock   in   PLL lock, asynchronous to clk
//   restart    in   single-cycle pulse, leaves FAIL with retries cleared
//   pll_rst    out  active-high PLL reset
//   sys_rst_n  out  active-low reset for PLL-clocked logic, high only in RUN
//   lock_lost  out  one-cycle pulse when lock drops in RUN
//   fail       out  high in FAIL
//   retry_cnt  out  timeout retries used in the current sequence
//   state      out  debug state: RESET=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
module pll_lock_rst_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 256,
    parameter int unsigned MAX_RETRY           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int unsigned RW = (RST_PULSE_CYCLES    > 1) ? $clog2(RST_PULSE_CYCLES)    : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned SW = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;

    localparam logic [RW-1:0] RST_LAST = RW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] ST_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_sync1;
    logic          r_lock_s;
    logic [RW-1:0] r_rst_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [SW-1:0] r_st_cnt;
    logic [3:0]    r_retry;
    logic [3:0]    w_retry_nxt;
    logic          r_pll_rst;
    logic          r_sys_rst_n;
    logic          r_lock_lost;
    logic          r_fail;
    logic          w_pll_rst;
    logic          w_sys_rst_n;
    logic          w_lock_lost;
    logic          w_fail;
    logic          w_rst_done;
    logic          w_timeout;
    logic          w_stable_done;

    assign w_rst_done    = (r_rst_cnt == RST_LAST);
    // >= guards the saturated case where lock arrives on the last budget cycle
    assign w_timeout     = (r_to_cnt >= TO_LAST);
    assign w_stable_done = (r_st_cnt >= ST_LAST);

    // State, synchroniser, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_rst_cnt   <= '0;
            r_to_cnt    <= '0;
            r_st_cnt    <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_lock_lost <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_sync1     <= pll_lock;
            r_lock_s    <= r_sync1;
            r_state     <= w_next;
            r_retry     <= w_retry_nxt;
            r_pll_rst   <= w_pll_rst;
            r_sys_rst_n <= w_sys_rst_n;
            r_lock_lost <= w_lock_lost;
            r_fail      <= w_fail;

            if (r_state == S_RESET && w_next == S_RESET) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end else begin
                r_rst_cnt <= '0;
            end

            // The budget spans WAIT_LOCK and STABLE together, so a lock glitch
            // that bounces back to WAIT_LOCK does not restart it.
            if (r_state == S_WAIT_LOCK || r_state == S_STABLE) begin
                if (r_to_cnt != '1) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end

            if (r_state == S_STABLE && w_next == S_STABLE && r_lock_s) begin
                if (r_st_cnt != '1) begin
                    r_st_cnt <= r_st_cnt + 1'b1;
                end
            end else begin
                r_st_cnt <= '0;
            end
        end
    end

    // Next state and retry count
    always_comb begin
        w_next      = r_state;
        w_retry_nxt = r_retry;
        case (r_state)
            S_RESET: begin
                if (w_rst_done) begin
                    w_next = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_next = S_STABLE;
                end else if (w_timeout) begin
                    if (r_retry >= RETRY_MAX) begin
                        w_next = S_FAIL;
                    end else begin
                        w_next      = S_RESET;
                        w_retry_nxt = r_retry + 1'b1;
                    end
                end
            end
            S_STABLE: begin
                if (w_timeout) begin
                    if (r_retry >= RETRY_MAX) begin
                        w_next = S_FAIL;
                    end else begin
                        w_next      = S_RESET;
                        w_retry_nxt = r_retry + 1'b1;
                    end
                end else if (!r_lock_s) begin
                    w_next = S_WAIT_LOCK;
                end else if (w_stable_done) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!r_lock_s) begin
                    w_next = S_RESET;
                end
            end
            S_FAIL: begin
                if (restart) begin
                    w_next      = S_RESET;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_next      = S_RESET;
                w_retry_nxt = '0;
            end
        endcase
        if (w_next == S_RUN) begin
            w_retry_nxt = '0;
        end
    end

    // Outputs decoded from the next state so they register alongside it
    always_comb begin
        w_pll_rst   = (w_next == S_RESET) || (w_next == S_FAIL);
        w_sys_rst_n = (w_next == S_RUN);
        w_fail      = (w_next == S_FAIL);
        w_lock_lost = (r_state == S_RUN) && (w_next == S_RESET);
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst_n = r_sys_rst_n;
    assign lock_lost = r_lock_lost;
    assign fail      = r_fail;
    assign retry_cnt = r_retry;
    assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_rst_ctrl.sv
// tb_pll_lock_rst_ctrl
//   Scoreboard bench for pll_lock_rst_ctrl with RST_PULSE_CYCLES=4,
//   LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8, MAX_RETRY=2.
//   Scenarios push expected output events (pll_rst pulse widths, release
//   latency, lock_lost latency, fail entry) to a queue; a negedge monitor pops
//   and compares them as the DUT produces them. Point checks cover states.
module tb_pll_lock_rst_ctrl;

    localparam int unsigned RP = 4;
    localparam int unsigned TO = 50;
    localparam int unsigned ST = 8;
    localparam int unsigned MR = 2;

    localparam int EV_PRST = 0;
    localparam int EV_UP   = 1;
    localparam int EV_LOST = 2;
    localparam int EV_FAIL = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   t_mark  = 0;

    pll_lock_rst_ctrl #(
        .RST_PULSE_CYCLES   (RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (ST),
        .MAX_RETRY          (MR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_rst_n(sys_rst_n),
        .lock_lost(lock_lost),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .state    (state)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; stimulus reads it 1 ns after an edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            EV_PRST: return "prst_width";
            EV_UP:   return "release_latency";
            EV_LOST: return "lost_latency";
            default: return "fail_retry";
        endcase
    endfunction

    task automatic sb_push(input int k, input int v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int k, input int v);
        exp_t e;
        if (sb.size() == 0) begin
            chk_eq({"sb_unexpected_", kname(k)}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk_eq({"sb_kind_", kname(k)}, k, e.kind);
            chk_eq({"sb_", kname(k)}, v, e.val);
        end
    endtask

    // Event monitor
    initial begin : monitor
        int   prst_w;
        logic sys_prev;
        logic fail_prev;
        prst_w    = 0;
        sys_prev  = 1'b0;
        fail_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prst_w    = 0;
                sys_prev  = 1'b0;
                fail_prev = 1'b0;
            end else begin
                if (pll_rst) begin
                    prst_w++;
                end else if (prst_w > 0) begin
                    sb_pop(EV_PRST, prst_w);
                    prst_w = 0;
                end
                if (sys_rst_n && !sys_prev) sb_pop(EV_UP, cyc - t_mark);
                if (lock_lost) sb_pop(EV_LOST, cyc - t_mark);
                if (fail && !fail_prev) sb_pop(EV_FAIL, int'(retry_cnt));
                sys_prev  = sys_rst_n;
                fail_prev = fail;
            end
        end
    end

    function automatic logic sel(input int s);
        case (s)
            0:       return pll_rst;
            1:       return sys_rst_n;
            2:       return lock_lost;
            default: return fail;
        endcase
    endfunction

    // Returns on the first negedge where the signal holds val, or flags expiry
    task automatic wait_for(input int s, input logic val, input int budget, input string tag);
        logic cur;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cur = sel(s);
            if (cur == val) return;
        end
        chk_eq({tag, "_timeout"}, int'(cur), int'(val));
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk_eq({tag, "_state"}, int'(state), 0);
        chk_eq({tag, "_pll_rst"}, int'(pll_rst), 1);
        chk_eq({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
        chk_eq({tag, "_lock_lost"}, int'(lock_lost), 0);
        chk_eq({tag, "_fail"}, int'(fail), 0);
        chk_eq({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    // Assert reset, check reset values, release just after a rising edge
    task automatic do_reset(input string tag);
        wait_cyc(1);
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        #1;
        chk_rst(tag);
        wait_cyc(2);
        rst_n  = 1'b1;
        t_mark = cyc;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stim
        int t_f;
        int r;

        // Normal bring-up: lock 20 cycles after pll_rst falls
        sb_push(EV_PRST, RP);
        sb_push(EV_UP, ST + 3);
        do_reset("rst_bringup");
        wait_for(0, 1'b0, 10, "bringup_prst_fall");
        wait_cyc(20);
        pll_lock = 1'b1;
        t_mark   = cyc;
        wait_for(1, 1'b1, 30, "bringup_release");
        chk_eq("bringup_state", int'(state), 3);
        chk_eq("bringup_retry", int'(retry_cnt), 0);
        chk_eq("bringup_pll_rst", int'(pll_rst), 0);

        // restart outside FAIL has no effect
        wait_cyc(1);
        restart = 1'b1;
        wait_cyc(1);
        restart = 1'b0;
        @(negedge clk);
        chk_eq("restart_ignored_state", int'(state), 3);
        chk_eq("restart_ignored_sys", int'(sys_rst_n), 1);

        // Loss of lock in RUN: two synchroniser stages plus the registered output
        sb_push(EV_LOST, 3);
        sb_push(EV_PRST, RP);
        wait_cyc(1);
        pll_lock = 1'b0;
        t_mark   = cyc;
        wait_for(2, 1'b1, 10, "loss_lock_lost");
        chk_eq("loss_sys_rst_n", int'(sys_rst_n), 0);
        chk_eq("loss_state", int'(state), 0);
        chk_eq("loss_pll_rst", int'(pll_rst), 1);
        @(negedge clk);
        chk_eq("loss_pulse_single", int'(lock_lost), 0);
        wait_for(0, 1'b0, 10, "loss_prst_fall");
        chk_eq("loss_retry", int'(retry_cnt), 0);
        chk_eq("loss_state_wait", int'(state), 1);

        // Lock glitch during STABLE
        sb_push(EV_PRST, RP);
        sb_push(EV_UP, ST + 3);
        do_reset("rst_glitch");
        wait_for(0, 1'b0, 10, "glitch_prst_fall");
        wait_cyc(1);
        pll_lock = 1'b1;
        wait_cyc(4);
        chk_eq("glitch_in_stable", int'(state), 2);
        pll_lock = 1'b0;
        wait_cyc(1);
        pll_lock = 1'b1;
        t_mark   = cyc;
        wait_cyc(2);
        chk_eq("glitch_back_to_wait", int'(state), 1);
        chk_eq("glitch_sys_low", int'(sys_rst_n), 0);
        wait_for(1, 1'b1, 20, "glitch_release");
        chk_eq("glitch_retry", int'(retry_cnt), 0);

        // Budget edge: lock at w+38 reaches RUN on the last budget cycle
        sb_push(EV_PRST, RP);
        sb_push(EV_UP, ST + 3);
        do_reset("rst_edge_ok");
        wait_for(0, 1'b0, 10, "edge_ok_prst_fall");
        wait_cyc(38);
        pll_lock = 1'b1;
        t_mark   = cyc;
        wait_for(1, 1'b1, 20, "edge_ok_release");
        chk_eq("edge_ok_state", int'(state), 3);

        // Budget edge: lock at w+39 completes with the timeout, timeout wins
        sb_push(EV_PRST, RP);
        sb_push(EV_PRST, RP);
        do_reset("rst_edge_to");
        wait_for(0, 1'b0, 10, "edge_to_prst_fall");
        wait_cyc(39);
        pll_lock = 1'b1;
        wait_for(0, 1'b1, 20, "edge_to_repulse");
        chk_eq("edge_to_state", int'(state), 0);
        chk_eq("edge_to_retry", int'(retry_cnt), 1);
        chk_eq("edge_to_sys", int'(sys_rst_n), 0);
        wait_for(0, 1'b0, 10, "edge_to_prst_fall2");

        // Timeout then lock
        sb_push(EV_PRST, RP);
        sb_push(EV_PRST, RP);
        sb_push(EV_UP, ST + 3);
        do_reset("rst_timeout");
        wait_for(0, 1'b0, 10, "timeout_prst_fall");
        wait_for(0, 1'b1, 60, "timeout_repulse");
        chk_eq("timeout_retry", int'(retry_cnt), 1);
        chk_eq("timeout_state", int'(state), 0);
        wait_for(0, 1'b0, 10, "timeout_prst_fall2");
        wait_cyc(5);
        pll_lock = 1'b1;
        t_mark   = cyc;
        wait_for(1, 1'b1, 20, "timeout_release");
        chk_eq("timeout_run_retry", int'(retry_cnt), 0);
        chk_eq("timeout_run_state", int'(state), 3);

        // Failure: lock never arrives
        sb_push(EV_PRST, RP);
        sb_push(EV_PRST, RP);
        sb_push(EV_PRST, RP);
        sb_push(EV_FAIL, MR);
        do_reset("rst_fail");
        wait_for(3, 1'b1, 250, "fail_enter");
        t_f = cyc;
        chk_eq("fail_state", int'(state), 4);
        chk_eq("fail_pll_rst", int'(pll_rst), 1);
        chk_eq("fail_retry", int'(retry_cnt), MR);
        chk_eq("fail_sys", int'(sys_rst_n), 0);
        wait_cyc(5);
        chk_eq("fail_latched", int'(fail), 1);
        chk_eq("fail_pll_rst_held", int'(pll_rst), 1);
        r = cyc;
        // FAIL keeps pll_rst high until restart, then the 4-cycle RESET follows
        sb_push(EV_PRST, r - t_f + 5);
        restart = 1'b1;
        wait_cyc(1);
        restart = 1'b0;
        @(negedge clk);
        chk_eq("restart_fail", int'(fail), 0);
        chk_eq("restart_retry", int'(retry_cnt), 0);
        chk_eq("restart_state", int'(state), 0);
        chk_eq("restart_pll_rst", int'(pll_rst), 1);
        wait_for(0, 1'b0, 10, "restart_prst_fall");

        // Mid-sequence asynchronous reset during STABLE
        sb_push(EV_PRST, RP);
        do_reset("rst_mid");
        wait_for(0, 1'b0, 10, "mid_prst_fall");
        wait_cyc(1);
        pll_lock = 1'b1;
        wait_cyc(4);
        chk_eq("mid_in_stable", int'(state), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst("mid_async");
        wait_cyc(2);
        // Lock already high: 4 RESET + 1 WAIT_LOCK + 8 STABLE cycles after release
        sb_push(EV_PRST, RP);
        sb_push(EV_UP, RP + 1 + ST);
        rst_n  = 1'b1;
        t_mark = cyc;
        wait_for(1, 1'b1, 30, "mid_release");
        chk_eq("mid_run_state", int'(state), 3);

        repeat (2) @(negedge clk);
        chk_eq("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
